bp_be_acc_wb_streamer: RTL

Writeback streamer directly downstream of the tensor accelerator pipe (`bp_be_pipe_acc`). It accepts one computed result block plus its destination address and serializes the block into fill-width beats of an uncached write message on the memory forward channel. It counts write acknowledgements returning on the reverse channel to bound outstanding writes. It reports busy and back-pressure panic status to the pipe.

---
 rtl/bp_be_acc_wb_streamer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/bp_be_acc_wb_streamer.sv
// Accelerator writeback streamer: serializes one result block into fill-width beats
// of an uncached write, bounds outstanding writes by counting acks, reports stall panic.
//   state | meaning
//   eIDLE | waiting for a result block (accepted only below the outstanding limit)
//   eSEND | presenting beats of the captured block on the forward channel
module bp_be_acc_wb_streamer #(
    parameter int block_width_p     = 512,
    parameter int fill_width_p      = 64,
    parameter int addr_width_p      = 40,
    parameter int lce_id_width_p    = 4,
    parameter int max_outstanding_p = 4,
    parameter int stall_thresh_p    = 16,
    localparam int beats_lp         = block_width_p / fill_width_p,
    localparam int cnt_width_lp     = (beats_lp > 1) ? $clog2(beats_lp) : 1
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [lce_id_width_p-1:0] lce_id_i,
    input  logic [block_width_p-1:0]  data_i,
    input  logic [addr_width_p-1:0]   addr_i,
    input  logic                      v_i,
    output logic                      ready_and_o,
    output logic [addr_width_p-1:0]   fwd_addr_o,
    output logic [lce_id_width_p-1:0] fwd_lce_id_o,
    output logic [fill_width_p-1:0]   fwd_data_o,
    output logic [cnt_width_lp-1:0]   fwd_cnt_o,
    output logic                      fwd_last_o,
    output logic                      fwd_v_o,
    input  logic                      fwd_ready_and_i,
    input  logic                      rev_v_i,
    input  logic                      rev_last_i,
    output logic                      rev_ready_and_o,
    output logic                      busy_o,
    output logic                      panic_o,
    output logic                      err_o
);

    localparam int offset_width_lp = $clog2(block_width_p / 8);
    localparam int out_width_lp    = $clog2(max_outstanding_p + 1);
    localparam int stall_width_lp  = $clog2(stall_thresh_p + 1);

    typedef enum logic {eIDLE, eSEND} state_e;

    state_e                                      state_q;
    logic [beats_lp-1:0][fill_width_p-1:0]       data_q;
    logic [addr_width_p-1:0]                     addr_q;
    logic [lce_id_width_p-1:0]                   lce_id_q;
    logic [cnt_width_lp-1:0]                     cnt_q;
    logic [out_width_lp-1:0]                     out_q;
    logic [stall_width_lp-1:0]                   stall_q;
    logic                                        err_q;

    logic blk_acc, beat_acc, last_acc, ack, stalled;

    assign fwd_v_o         = (state_q == eSEND);
    assign fwd_last_o      = fwd_v_o && (cnt_q == cnt_width_lp'(beats_lp - 1));
    assign fwd_data_o      = data_q[cnt_q];
    assign fwd_cnt_o       = cnt_q;
    assign fwd_addr_o      = addr_q;
    assign fwd_lce_id_o    = lce_id_q;
    assign ready_and_o     = (state_q == eIDLE) && (out_q < out_width_lp'(max_outstanding_p));
    assign rev_ready_and_o = 1'b1;
    assign busy_o          = fwd_v_o || (out_q != '0);
    assign panic_o         = (stall_q == stall_width_lp'(stall_thresh_p));
    assign err_o           = err_q;

    assign blk_acc  = v_i && ready_and_o;
    assign beat_acc = fwd_v_o && fwd_ready_and_i;
    assign last_acc = beat_acc && fwd_last_o;
    assign ack      = rev_v_i && rev_last_i;
    assign stalled  = fwd_v_o && !fwd_ready_and_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= eIDLE;
            data_q   <= '0;
            addr_q   <= '0;
            lce_id_q <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            stall_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                eIDLE: begin
                    if (blk_acc) begin
                        data_q   <= data_i;
                        addr_q   <= {addr_i[addr_width_p-1:offset_width_lp], {offset_width_lp{1'b0}}};
                        lce_id_q <= lce_id_i;
                        cnt_q    <= '0;
                        state_q  <= eSEND;
                    end
                end
                eSEND: begin
                    if (last_acc) begin
                        cnt_q   <= '0;
                        state_q <= eIDLE;
                    end else if (beat_acc) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= eIDLE;
            endcase

            // Ack against an empty counter is a protocol error; keep the count at zero.
            if (last_acc && !ack) begin
                out_q <= out_q + 1'b1;
            end else if (ack && !last_acc) begin
                if (out_q == '0) err_q <= 1'b1;
                else             out_q <= out_q - 1'b1;
            end

            if (stalled) begin
                if (stall_q != stall_width_lp'(stall_thresh_p)) stall_q <= stall_q + 1'b1;
            end else begin
                stall_q <= '0;
            end
        end
    end

endmodule
